// File: rtl/dmem_arb_pkg.sv
// Shared types and default limits for the data-memory arbiter.
// Optional statistics are enabled with DMEM_ARB_STATS_EN.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    LOCK = 2'd1,
    COOL = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_CORE = 1'b0,
    REQ_HOST = 1'b1
  } req_id_t;

  localparam int STARVE_MAX_DEF = 4;
  localparam int LOCK_MAX_DEF   = 16;

endpackage

// File: rtl/dmem_arb_stats.sv
// Saturating grant/conflict counters for the data-memory arbiter.
// Instantiated by dmem_arbiter only when DMEM_ARB_STATS_EN is defined.
module dmem_arb_stats
  import dmem_arb_pkg::*;
#(
  parameter int SW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_gnt,
  input  logic          host_gnt,
  input  logic          conflict,
  output logic [SW-1:0] stat_core_cyc,
  output logic [SW-1:0] stat_host_cyc,
  output logic [SW-1:0] stat_conflict
);

  localparam logic [SW-1:0] TOP = '1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_core_cyc <= '0;
      stat_host_cyc <= '0;
      stat_conflict <= '0;
    end else begin
      if (core_gnt && stat_core_cyc != TOP)
        stat_core_cyc <= stat_core_cyc + 1'b1;
      if (host_gnt && stat_host_cyc != TOP)
        stat_host_cyc <= stat_host_cyc + 1'b1;
      if (conflict && stat_conflict != TOP)
        stat_conflict <= stat_conflict + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Core/host arbiter for the single-port data memory, with starvation
// guard and bounded host lock. Stats ports under DMEM_ARB_STATS_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int LOCK_MAX   = LOCK_MAX_DEF,
  parameter int SW         = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_gnt,
  output logic          core_stall,
  input  logic          host_req,
  input  logic          host_we,
  input  logic          host_lock,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic [DW-1:0] rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [SW-1:0] stat_core_cyc,
  output logic [SW-1:0] stat_host_cyc,
  output logic [SW-1:0] stat_conflict
`endif
);

  localparam int SCW = $clog2(STARVE_MAX + 1);
  localparam int LCW = $clog2(LOCK_MAX);
  localparam logic [SCW-1:0] STARVE_TOP = SCW'(STARVE_MAX);
  localparam logic [LCW-1:0] LOCK_LAST  = LCW'(LOCK_MAX - 1);

  arb_state_t     state, state_nxt;
  logic [SCW-1:0] starve_cnt, starve_nxt;
  logic [LCW-1:0] lock_cnt, lock_nxt;
  logic           conflict;
  logic           host_first;
  req_id_t        owner;

  assign conflict = core_req & host_req;

  always_comb begin
    host_first = 1'b0;
    unique case (state)
      ARB:     host_first = (starve_cnt == STARVE_TOP);
      LOCK:    host_first = host_lock;
      default: host_first = 1'b0;
    endcase
  end

  always_comb begin
    owner = REQ_CORE;
    unique case (1'b1)
      conflict:
        owner = host_first ? REQ_HOST : REQ_CORE;
      host_req & ~core_req:
        owner = REQ_HOST;
      default:
        owner = REQ_CORE;
    endcase
  end

  assign host_gnt   = host_req & (owner == REQ_HOST);
  assign core_gnt   = core_req & (owner == REQ_CORE);
  assign core_stall = core_req & ~core_gnt;

  assign mem_we    = (core_gnt & core_we) | (host_gnt & host_we);
  assign mem_addr  = host_gnt ? host_addr : core_addr;
  assign mem_wdata = host_gnt ? host_wdata : core_wdata;
  assign rdata     = mem_rdata;

  // Any LOCK cycle without a locked host grant falls back to ARB.
  always_comb begin
    state_nxt = ARB;
    lock_nxt  = '0;
    unique case (state)
      ARB: begin
        if (host_gnt & host_lock) begin
          state_nxt = LOCK;
          lock_nxt  = LCW'(1);
        end
      end
      LOCK: begin
        if (host_gnt & host_lock) begin
          if (lock_cnt == LOCK_LAST) begin
            state_nxt = COOL;
          end else begin
            state_nxt = LOCK;
            lock_nxt  = lock_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = ARB;
      end
    endcase
  end

  always_comb begin
    starve_nxt = starve_cnt;
    unique case (1'b1)
      host_gnt:
        starve_nxt = '0;
      host_req & ~host_gnt & (starve_cnt != STARVE_TOP):
        starve_nxt = starve_cnt + 1'b1;
      default:
        starve_nxt = starve_cnt;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ARB;
      starve_cnt <= '0;
      lock_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      lock_cnt   <= lock_nxt;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  dmem_arb_stats #(
    .SW(SW)
  ) u_stats (
    .clk          (clk),
    .reset        (reset),
    .core_gnt     (core_gnt),
    .host_gnt     (host_gnt),
    .conflict     (conflict),
    .stat_core_cyc(stat_core_cyc),
    .stat_host_cyc(stat_host_cyc),
    .stat_conflict(stat_conflict)
  );
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus protocol-legal random
// traffic against a cycle-level arbitration and memory model.
module tb_dmem_arbiter;

  localparam int SMAX = 4;
  localparam int LMAX = 16;
  localparam int SW   = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       core_req, core_we, core_gnt, core_stall;
  logic [7:0] core_addr, core_wdata;
  logic       host_req, host_we, host_lock, host_gnt;
  logic [7:0] host_addr, host_wdata;
  logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic       mem_we;
`ifdef DMEM_ARB_STATS_EN
  logic [SW-1:0] stat_core_cyc, stat_host_cyc, stat_conflict;
`endif

  logic [7:0] ram [256];
  logic [7:0] mdl_mem [256];

  int n_chk = 0;
  int n_pass = 0;

  int starved, burst;
  bit cool;
  bit exp_cg, exp_hg, exp_st, exp_we;
  logic [7:0] exp_rd;
  int cnt_core, cnt_host, cnt_conf;

  always #5 clk = ~clk;

  initial for (int i = 0; i < 256; i++) ram[i] = 8'(i * 7);
  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;

  dmem_arbiter #(
    .AW(8), .DW(8), .STARVE_MAX(SMAX), .LOCK_MAX(LMAX), .SW(SW)
  ) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_stall(core_stall),
    .host_req(host_req), .host_we(host_we), .host_lock(host_lock),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .rdata(rdata),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stat_core_cyc(stat_core_cyc),
    .stat_host_cyc(stat_host_cyc),
    .stat_conflict(stat_conflict)
`endif
  );

  task automatic drive(input bit cr, input bit cw, input logic [7:0] ca,
                       input logic [7:0] cd, input bit hr, input bit hw,
                       input bit hl, input logic [7:0] ha, input logic [7:0] hd);
    core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
    host_req = hr; host_we = hw; host_lock = hl;
    host_addr = ha; host_wdata = hd;
  endtask

  task automatic model_reset;
    starved = 0; burst = 0; cool = 0;
    cnt_core = 0; cnt_host = 0; cnt_conf = 0;
  endtask

  // Who should win this cycle, from the arbitration rules.
  task automatic model_eval;
    bit host_pref;
    if (burst > 0) host_pref = host_lock;
    else if (cool) host_pref = 1'b0;
    else host_pref = (starved == SMAX);
    exp_hg = host_req && (!core_req || host_pref);
    exp_cg = core_req && !exp_hg;
    exp_st = core_req && !exp_cg;
    exp_we = (exp_cg && core_we) || (exp_hg && host_we);
    exp_rd = exp_hg ? mdl_mem[host_addr] : mdl_mem[core_addr];
  endtask

  task automatic model_commit;
    if (exp_hg && host_we) mdl_mem[host_addr] = host_wdata;
    if (exp_cg && core_we) mdl_mem[core_addr] = core_wdata;
    cnt_core += int'(exp_cg);
    cnt_host += int'(exp_hg);
    cnt_conf += int'(core_req && host_req);
    if (burst > 0) begin
      if (exp_hg && host_lock) begin
        burst++;
        if (burst == LMAX) begin
          burst = 0;
          cool = 1;
        end
      end else begin
        burst = 0;
      end
    end else if (cool) begin
      cool = 0;
    end else if (exp_hg && host_lock) begin
      burst = 1;
    end
    if (exp_hg) starved = 0;
    else if (host_req && starved < SMAX) starved++;
  endtask

  task automatic tick;
    @(posedge clk);
    if (reset) model_commit();
    #1;
  endtask

  task automatic do_reset;
    drive(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset;
    drive(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    reset = 1'b0;
    model_reset();
    #3;
    n_chk++;
    if ({core_gnt, host_gnt, core_stall, mem_we} !== 4'b0000)
      $display("FAIL reset_idle: got %b want 0000",
               {core_gnt, host_gnt, core_stall, mem_we});
    else n_pass++;
`ifdef DMEM_ARB_STATS_EN
    n_chk++;
    if ({stat_core_cyc, stat_host_cyc, stat_conflict} !== '0)
      $display("FAIL reset_stats: got %h/%h/%h want 0",
               stat_core_cyc, stat_host_cyc, stat_conflict);
    else n_pass++;
`endif
    @(posedge clk);
    #1;
    reset = 1'b1;
    #3;
    n_chk++;
    if ({core_gnt, host_gnt, core_stall, mem_we} !== 4'b0000)
      $display("FAIL post_reset_idle: got %b want 0000",
               {core_gnt, host_gnt, core_stall, mem_we});
    else n_pass++;
    tick();
  endtask

  task automatic test_core_write_read;
    do_reset();
    drive(1, 1, 8'h10, 8'hA5, 0, 0, 0, 8'h00, 8'h00);
    model_eval();
    #3;
    n_chk++;
    if ({core_gnt, host_gnt, core_stall, mem_we} !== 4'b1001)
      $display("FAIL core_write: got %b want 1001",
               {core_gnt, host_gnt, core_stall, mem_we});
    else n_pass++;
    tick();
    drive(1, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    model_eval();
    #3;
    n_chk++;
    if ({core_gnt, mem_we, rdata} !== {1'b1, 1'b0, 8'hA5})
      $display("FAIL core_read: gnt=%b we=%b rdata=%h want 1 0 a5",
               core_gnt, mem_we, rdata);
    else n_pass++;
    tick();
  endtask

  task automatic test_starvation;
    bit eh;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 8'(i), 8'h00, 1, 0, 0, 8'h80, 8'h00);
      model_eval();
      eh = (i % 5 == 4);
      #3;
      n_chk++;
      if ({core_gnt, host_gnt, core_stall} !== {!eh, eh, eh})
        $display("FAIL starve cyc%0d: got %b want %b", i + 1,
                 {core_gnt, host_gnt, core_stall}, {!eh, eh, eh});
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_lock_burst;
    bit eh;
    do_reset();
    for (int i = 0; i < 25; i++) begin
      drive(1, 0, 8'(i), 8'h00, 1, 1, 1, 8'h20, 8'(i));
      model_eval();
      eh = (i >= 4 && i <= 19) || i == 24;
      #3;
      n_chk++;
      if ({core_gnt, host_gnt, mem_we} !== {!eh, eh, eh})
        $display("FAIL lock_burst cyc%0d: got %b want %b", i + 1,
                 {core_gnt, host_gnt, mem_we}, {!eh, eh, eh});
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_lock_drop;
    bit eh;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 8'h30, 8'h00, 1, 0, i != 7, 8'h31, 8'h00);
      model_eval();
      eh = (i >= 4 && i <= 6);
      #3;
      n_chk++;
      if ({core_gnt, host_gnt, core_stall} !== {!eh, eh, eh})
        $display("FAIL lock_drop cyc%0d: got %b want %b", i + 1,
                 {core_gnt, host_gnt, core_stall}, {!eh, eh, eh});
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_ungranted_write;
    do_reset();
    drive(0, 0, 8'h00, 8'h00, 1, 1, 0, 8'h40, 8'h11);
    model_eval();
    #3;
    n_chk++;
    if ({core_gnt, host_gnt, mem_we} !== 3'b011)
      $display("FAIL host_preload: got %b want 011",
               {core_gnt, host_gnt, mem_we});
    else n_pass++;
    tick();
    drive(1, 0, 8'h40, 8'h00, 1, 1, 0, 8'h40, 8'hEE);
    model_eval();
    #3;
    n_chk++;
    if ({core_gnt, host_gnt, mem_we, rdata} !== {3'b100, 8'h11})
      $display("FAIL ungranted_write: gnt=%b%b we=%b rdata=%h want 1 0 0 11",
               core_gnt, host_gnt, mem_we, rdata);
    else n_pass++;
    tick();
    drive(1, 0, 8'h40, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    model_eval();
    #3;
    n_chk++;
    if (rdata !== 8'h11)
      $display("FAIL ungranted_readback: got %h want 11", rdata);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid_lock;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 8'h50, 8'h00, 1, 0, 1, 8'h51, 8'h00);
      model_eval();
      tick();
    end
    drive(1, 0, 8'h50, 8'h00, 1, 0, 1, 8'h51, 8'h00);
    #1;
    n_chk++;
    if ({core_gnt, host_gnt} !== 2'b01)
      $display("FAIL in_lock: got %b want 01", {core_gnt, host_gnt});
    else n_pass++;
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    n_chk++;
    if ({core_gnt, host_gnt, core_stall, mem_we} !== 4'b1000)
      $display("FAIL reset_mid_lock: got %b want 1000",
               {core_gnt, host_gnt, core_stall, mem_we});
    else n_pass++;
`ifdef DMEM_ARB_STATS_EN
    n_chk++;
    if ({stat_core_cyc, stat_host_cyc, stat_conflict} !== '0)
      $display("FAIL reset_mid_lock_stats: got %h/%h/%h want 0",
               stat_core_cyc, stat_host_cyc, stat_conflict);
    else n_pass++;
`endif
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_eval();
    #3;
    n_chk++;
    if ({core_gnt, host_gnt, core_stall} !== 3'b100)
      $display("FAIL after_reset_conflict: got %b want 100",
               {core_gnt, host_gnt, core_stall});
    else n_pass++;
    tick();
  endtask

  task automatic test_random;
    bit cr, cw, hr, hw, hl, cpend, hpend;
    logic [7:0] ca, cd, ha, hd;
    do_reset();
    cpend = 0; hpend = 0; hl = 0;
    cr = 0; cw = 0; hr = 0; hw = 0;
    ca = 0; cd = 0; ha = 0; hd = 0;
    for (int i = 0; i < 400; i++) begin
      if (!cpend) begin
        cr = $urandom_range(0, 3) != 0;
        cw = $urandom_range(0, 1) == 1;
        ca = 8'($urandom_range(0, 15));
        cd = 8'($urandom);
      end
      if (!hpend) begin
        hr = $urandom_range(0, 3) != 0;
        hw = $urandom_range(0, 1) == 1;
        ha = 8'($urandom_range(0, 15));
        hd = 8'($urandom);
      end
      if ($urandom_range(0, 9) == 0) hl = !hl;
      drive(cr, cw, ca, cd, hr, hw, hl, ha, hd);
      model_eval();
      #3;
      n_chk++;
      if ({core_gnt, host_gnt, core_stall, mem_we} !==
          {exp_cg, exp_hg, exp_st, exp_we})
        $display("FAIL rand_gnt cyc%0d: got %b want %b", i,
                 {core_gnt, host_gnt, core_stall, mem_we},
                 {exp_cg, exp_hg, exp_st, exp_we});
      else n_pass++;
      if (exp_cg || exp_hg) begin
        n_chk++;
        if (rdata !== exp_rd)
          $display("FAIL rand_rdata cyc%0d: got %h want %h", i, rdata, exp_rd);
        else n_pass++;
      end
      cpend = cr && !core_gnt;
      hpend = hr && !host_gnt;
      tick();
    end
`ifdef DMEM_ARB_STATS_EN
    n_chk++;
    if ({stat_core_cyc, stat_host_cyc, stat_conflict} !==
        {SW'(cnt_core), SW'(cnt_host), SW'(cnt_conf)})
      $display("FAIL rand_stats: got %0d/%0d/%0d want %0d/%0d/%0d",
               stat_core_cyc, stat_host_cyc, stat_conflict,
               cnt_core, cnt_host, cnt_conf);
    else n_pass++;
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mdl_mem[i] = 8'(i * 7);
    reset = 1'b1;
    drive(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    model_reset();
    #1;
    test_reset();
    test_core_write_read();
    test_starvation();
    test_lock_burst();
    test_lock_drop();
    test_ungranted_write();
    test_reset_mid_lock();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port 8-bit data memory between the core's load/store path and a host port used by the bench or loader. The host port preloads operands and reads back results. The core has priority by default. A starvation counter guarantees the host a slot, and a bounded lock lets the host run an uninterrupted burst. When the core loses a cycle, the arbiter raises a stall that holds the core's PC and register writes.

## Interface
Parameters:
- AW, 8, memory address width
- DW, 8, memory data width
- STARVE_MAX, 4, consecutive denied host cycles before the host wins a conflict (≥1)
- LOCK_MAX, 16, maximum consecutive host-granted cycles per lock (≥2)
- SW, 16, statistics counter width (used only with the stats feature)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, rising-edge
- reset  in  1  asynchronous active-low reset
- core_req, core_we  in  1 each  core access request and write enable
- core_addr  in  AW  core address
- core_wdata  in  DW  core write data
- core_gnt  out  1  core access performed this cycle
- core_stall  out  1  core_req & ~core_gnt
- host_req, host_we, host_lock  in  1 each  host request, write enable, burst-lock request
- host_addr  in  AW  host address
- host_wdata  in  DW  host write data
- host_gnt  out  1  host access performed this cycle
- rdata  out  DW  memory read data, passed combinationally to both requesters
- mem_we  out  1  write enable to the data memory
- mem_addr  out  AW  address to the data memory
- mem_wdata  out  DW  write data to the data memory
- mem_rdata  in  DW  combinational read data from the data memory

## Operation
- Grant is combinational from the current requests and registered state; at most one grant per cycle.
- Memory mux: the host drives mem_* when host_gnt=1; otherwise the core drives them.
- mem_we = (core_gnt & core_we) | (host_gnt & host_we); an ungranted write never reaches memory.
- A lone requester is always granted.
- The FSM state and the conflict rule are:
  - ARB: a conflict goes to the host if starve_cnt == STARVE_MAX, otherwise to the core. If the host is granted with host_lock=1, the next state is LOCK and lock_cnt←1.
  - LOCK: the host wins every conflict. Each host-granted cycle increments lock_cnt.
    - If lock_cnt+1 == LOCK_MAX in that cycle, the next state is COOL.
    - If host_req=0 or host_lock=0, the next state is ARB and the core wins any conflict in that cycle.
  - COOL: the core wins any conflict. A lone host request is granted but cannot enter LOCK. The next state is always ARB.
- starve_cnt is updated every cycle:
  - +1, saturating at STARVE_MAX, when host_req & ~host_gnt.
  - Cleared to 0 on host_gnt.
  - Held otherwise.
- Widths:
  - starve_cnt is $clog2(STARVE_MAX+1) bits.
  - lock_cnt is $clog2(LOCK_MAX) bits.
  - No counter wraps.

## Timing
- Zero-cycle latency: a grant and its memory access occur in the same cycle as the request. Writes commit at the next rising edge of clk; read data is valid in the grant cycle.
- A requester must hold req/we/addr/wdata stable until it sees a grant. Once granted, it may change them on the following cycle.
- Simultaneous events:
  - A host_lock rising in a conflict cycle in ARB with starve_cnt < STARVE_MAX takes no effect, because the core wins that cycle.
  - A host_req drop in LOCK returns the FSM to ARB at the next edge.
- Reset (asserted, asynchronous): state=ARB, starve_cnt=0, lock_cnt=0, stats=0.
  - Outputs follow the inputs combinationally, so with no requests every gnt, core_stall and mem_we is 0.
  - Reset asserted mid-lock aborts the lock immediately.

## Configuration
- DMEM_ARB_STATS_EN defined: adds the outputs stat_core_cyc, stat_host_cyc and stat_conflict, each SW bits.
  - They count core grants, host grants, and cycles with both requests asserted.
  - Each counter saturates at all-ones.
  - All three clear on reset.
- Not defined: the stat_* ports and their counters are absent. Arbitration behaviour is identical in both builds.

## Structure
- Package dmem_arb_pkg holds:
  - the arb_state_t enum {ARB, LOCK, COOL};
  - the requester id enum {REQ_CORE, REQ_HOST};
  - the default values of STARVE_MAX and LOCK_MAX.
- Sub-module dmem_arb_stats holds the three saturating counters. It is instantiated only under DMEM_ARB_STATS_EN.

## Test plan
- Reset, then core_req=1 with core_we=1, addr 0x10, wdata 0xA5, host idle → core_gnt=1 and mem_we=1 in the same cycle. A following read of 0x10 returns rdata=0xA5.
- Core and host both requesting continuously in ARB, STARVE_MAX=4 → core granted in cycles 1–4, host granted in cycle 5 with core_stall=1, core granted in cycles 6–9, and so on.
- Host wins a conflict on the starvation rule with host_lock=1 held and both requesting, LOCK_MAX=16 → host granted for 16 consecutive cycles, COOL cycle goes to the core, then the ARB starvation rule resumes.
- In LOCK, host drops host_lock after 3 granted cycles while the core requests → the core is granted the cycle host_lock=0; the next state is ARB.
- An ungranted host write (host_we=1, host_gnt=0) → mem_we=0 and the memory contents are unchanged.
- Reset pulsed mid-lock → outputs return to their reset values immediately. After release, a conflict goes to the core (state ARB, starve_cnt=0). With DMEM_ARB_STATS_EN, all stat_* read 0.
